// File: rtl/fixed_point_div_seq_if.sv
// Operand/result handshake bundle for the sequential Q8.4 divider.
// master = producer/consumer side, slave = divider side.
interface fixed_point_div_seq_if #(
  parameter int WIDTH = 12
);
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] quot;
  logic             errorFlag;

  modport master (
    output inValid, a, b, outReady,
    input  inReady, outValid, quot, errorFlag
  );

  modport slave (
    input  inValid, a, b, outReady,
    output inReady, outValid, quot, errorFlag
  );
endinterface

// File: rtl/fixed_point_div_seq.sv
// Multi-cycle signed Q(WIDTH-4).4 divider, one restoring step per clock, saturating.
// Optional macro FIXED_POINT_DIV_SEQ_PASSTHRU_EN lets a new op be accepted on the output handshake edge.
module fixed_point_div_seq #(
  parameter int WIDTH = 12
) (
  input logic                  clk,
  input logic                  rst,
  fixed_point_div_seq_if.slave bus
);

  localparam int DW = WIDTH + 4;
  localparam int CW = $clog2(WIDTH + 5);
  localparam logic [WIDTH-1:0] MAX_Q   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_Q   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [DW-1:0]    POS_LIM = DW'((1 << (WIDTH-1)) - 1);
  localparam logic [DW-1:0]    NEG_LIM = DW'(1 << (WIDTH-1));

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [DW-1:0]    qmag_q, qmag_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic             err_q, err_d;

  logic             inReadyInt;
  logic             outValidInt;
  logic             accept;
  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;
  logic [WIDTH:0]   remShift;
  logic             remFits;
  logic [WIDTH-1:0] remSub;
  logic [DW-1:0]    qNext;
  logic [WIDTH-1:0] satQuot;

  // Magnitudes fit in WIDTH unsigned bits, including |MIN_Q| = 2^(WIDTH-1).
  assign aMag = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
  assign bMag = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;

  assign accept   = bus.inValid && inReadyInt;
  assign remShift = {rem_q, dividend_q[DW-1]};
  assign remFits  = remShift >= {1'b0, divisor_q};
  assign remSub   = remFits ? WIDTH'(remShift - {1'b0, divisor_q}) : remShift[WIDTH-1:0];
  assign qNext    = {qmag_q[DW-2:0], remFits};

  always_comb begin
    satQuot = qNext[WIDTH-1:0];
    if (!sign_q) begin
      if (qNext > POS_LIM) satQuot = MAX_Q;
    end else if (qNext > NEG_LIM) begin
      satQuot = MIN_Q;
    end else begin
      satQuot = ~qNext[WIDTH-1:0] + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      qmag_q     <= '0;
      count_q    <= '0;
      sign_q     <= 1'b0;
      quot_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      qmag_q     <= qmag_d;
      count_q    <= count_d;
      sign_q     <= sign_d;
      quot_q     <= quot_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    qmag_d     = qmag_q;
    count_d    = count_q;
    sign_d     = sign_q;
    quot_d     = quot_q;
    err_d      = err_q;

    case (state_q)
      IDLE: ;
      DIVIDE: begin
        rem_d      = remSub;
        qmag_d     = qNext;
        dividend_d = {dividend_q[DW-2:0], 1'b0};
        count_d    = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          quot_d  = satQuot;
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.outReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An accept overrides the DONE->IDLE return when passthrough is enabled.
    if (accept) begin
      if (bus.b == '0) begin
        state_d = DONE;
        err_d   = 1'b1;
        quot_d  = bus.a[WIDTH-1] ? MIN_Q : MAX_Q;
      end else begin
        state_d    = DIVIDE;
        dividend_d = {aMag, 4'b0000};
        divisor_d  = bMag;
        rem_d      = '0;
        qmag_d     = '0;
        count_d    = CW'(DW);
        sign_d     = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      end
    end
  end

  always_comb begin
    outValidInt = (state_q == DONE);
`ifdef FIXED_POINT_DIV_SEQ_PASSTHRU_EN
    inReadyInt  = (state_q == IDLE) || ((state_q == DONE) && bus.outReady);
`else
    inReadyInt  = (state_q == IDLE);
`endif
  end

  assign bus.inReady   = inReadyInt;
  assign bus.outValid  = outValidInt;
  assign bus.quot      = quot_q;
  assign bus.errorFlag = err_q;

endmodule
